// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// Module : rf_pkg
// Brief  : Shared register-file sizes, requester IDs and ID-width helper.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;
    localparam int NUM_REGS  = 16;

    localparam int RQ_OPA = 0;
    localparam int RQ_OPB = 1;
    localparam int RQ_DBG = 2;

    // A single requester still needs a one-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Combinational round-robin / fixed-priority pick from a request vector.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import rf_pkg::*;
#(
    parameter int N     = 3,
    parameter int RR_EN = 1,
    localparam int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] winner_idx,
    output logic            any
);

    logic w_found;

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt        = '0;
        winner_idx = '0;
        w_found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i] && ((RR_EN == 0) || (ID_W'(i) >= ptr))) begin
                w_found    = 1'b1;
                winner_idx = ID_W'(i);
                gnt[i]     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && req[i]) begin
                w_found    = 1'b1;
                winner_idx = ID_W'(i);
                gnt[i]     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/rf_read_arbiter.sv
// ---------------------------------------------------------------------------
// Module : rf_read_arbiter
// Brief  : Shares the register-file read port among requesters, 2-cycle
//          tagged read with write-first forwarding.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_read_arbiter
    import rf_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int RR_EN  = 1,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rf_sel,
    input  logic [DATA_W-1:0]       rf_rdata,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    rvalid,
    output logic [ID_W-1:0]         rid,
    output logic [DATA_W-1:0]       rdata
);

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_winner;
    logic              w_any;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_bypass;

    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_s1_v;

    rr_arbiter #(
        .N     (N_REQ),
        .RR_EN (RR_EN)
    ) u_arb (
        .req        (req),
        .ptr        (r_ptr),
        .gnt        (w_gnt),
        .winner_idx (w_winner),
        .any        (w_any)
    );

    assign gnt = rst ? '0 : w_gnt;

    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // The register file commits this write at the same edge we capture rdata.
    assign w_bypass = wr_en && (wr_addr == rf_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            rf_sel  <= '0;
            r_s1_id <= '0;
            r_s1_v  <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
        end else begin
            if (w_any) begin
                rf_sel  <= w_sel_addr;
                r_s1_id <= w_winner;
                // Explicit compare keeps the wrap correct for non power-of-two N_REQ.
                r_ptr   <= (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);
            end
            r_s1_v <= w_any;
            rvalid <= r_s1_v;
            rid    <= r_s1_id;
            if (r_s1_v) begin
                rdata <= w_bypass ? wr_data : rf_rdata;
            end
        end
    end

endmodule

`default_nettype wire
